com_lane_inserter: RTL and testbench

Parametrised multi-lane comma/idle inserter for the PHY transmit path, placed between the byte-striping logic and the per-lane 8b/10b encoders. After reset or on retrain request it emits a comma training burst on all lanes. It then passes valid bytes and fills idle lane slots with the comma character. It periodically steals a fixed number of cycles to insert SKP ordered sets, back-pressuring upstream with `ready`.

---
 rtl/com_pkg.sv | 24 ++
 rtl/com_lane.sv | 46 ++++
 rtl/com_lane_inserter.sv | 121 ++++++++++++
 tb/tb_com_lane_inserter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
// Shared symbols, state encoding and sizing helper for the comma/idle lane inserter.
package com_pkg;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_SKP   = 8'h1C;

  typedef enum logic [1:0] {
    TRAIN,
    DATA,
    SKIP
  } com_state_t;

  typedef enum logic [1:0] {
    SEL_PASS,
    SEL_COMMA,
    SEL_SKP
  } lane_sel_t;

  // Counter width for a count of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/com_lane.sv
// One lane of the inserter: registered select between pass-through data, comma and SKP.
module com_lane
  import com_pkg::*;
#(
  parameter int           W     = 8,
  parameter logic [W-1:0] COMMA = W'(K_COMMA),
  parameter logic [W-1:0] SKP   = W'(K_SKP)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   sel,
  input  logic [W-1:0] data,
  output logic [W-1:0] sym_o,
  output logic         k_o
);

  logic [W-1:0] sym_d, sym_q;
  logic         k_d, k_q;

  always_comb begin
    sym_d = COMMA;
    k_d   = 1'b1;
    case (sel)
      SEL_PASS: begin
        sym_d = data;
        k_d   = 1'b0;
      end
      SEL_SKP:  sym_d = SKP;
      default:  sym_d = COMMA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_q <= '0;
      k_q   <= 1'b0;
    end else begin
      sym_q <= sym_d;
      k_q   <= k_d;
    end
  end

  assign sym_o = sym_q;
  assign k_o   = k_q;

endmodule

// File: rtl/com_lane_inserter.sv
// Multi-lane comma/idle inserter: training burst, data pass with comma fill, periodic SKP bursts.
module com_lane_inserter
  import com_pkg::*;
#(
  parameter int           LANES        = 4,
  parameter int           W            = 8,
  parameter logic [W-1:0] COMMA        = W'(K_COMMA),
  parameter logic [W-1:0] SKP          = W'(K_SKP),
  parameter int           TRAIN_LEN    = 16,
  parameter int           SKP_INTERVAL = 64,
  parameter int           SKP_LEN      = 2
) (
  input  logic               cclk,
  input  logic               default_values,
  input  logic               force_train,
  input  logic [LANES-1:0]   valid,
  input  logic [LANES*W-1:0] data_in,
  output logic               ready,
  output logic [LANES*W-1:0] data_out,
  output logic [LANES-1:0]   k_out,
  output logic               training
);

  localparam int TW = cnt_w(TRAIN_LEN);
  localparam int IW = cnt_w(SKP_INTERVAL);
  localparam int LW = cnt_w(SKP_LEN);

  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
  localparam logic [IW-1:0] INTV_LAST  = IW'(SKP_INTERVAL - 1);
  localparam logic [LW-1:0] SKPL_LAST  = LW'(SKP_LEN - 1);

  com_state_t    state_d, state_q;
  logic [TW-1:0] train_cnt_d, train_cnt_q;
  logic [IW-1:0] skp_cnt_d, skp_cnt_q;
  logic [LW-1:0] skp_len_cnt_d, skp_len_cnt_q;

  always_comb begin
    state_d       = state_q;
    train_cnt_d   = train_cnt_q;
    skp_cnt_d     = skp_cnt_q;
    skp_len_cnt_d = skp_len_cnt_q;
    unique case (state_q)
      TRAIN: begin
        if (train_cnt_q == TRAIN_LAST) begin
          train_cnt_d = '0;
          state_d     = DATA;
        end else begin
          train_cnt_d = train_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (skp_cnt_q == INTV_LAST) begin
          skp_cnt_d = '0;
          state_d   = SKIP;
        end else begin
          skp_cnt_d = skp_cnt_q + 1'b1;
        end
      end
      SKIP: begin
        if (skp_len_cnt_q == SKPL_LAST) begin
          skp_len_cnt_d = '0;
          state_d       = DATA;
        end else begin
          skp_len_cnt_d = skp_len_cnt_q + 1'b1;
        end
      end
      default: state_d = TRAIN;
    endcase
    // Retrain overrides any terminal count reached this cycle.
    if (force_train) begin
      state_d       = TRAIN;
      train_cnt_d   = '0;
      skp_cnt_d     = '0;
      skp_len_cnt_d = '0;
    end
  end

  always_ff @(posedge cclk) begin
    if (!default_values) begin
      state_q       <= TRAIN;
      train_cnt_q   <= '0;
      skp_cnt_q     <= '0;
      skp_len_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      train_cnt_q   <= train_cnt_d;
      skp_cnt_q     <= skp_cnt_d;
      skp_len_cnt_q <= skp_len_cnt_d;
    end
  end

  assign ready    = (state_q == DATA);
  assign training = (state_q == TRAIN);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [1:0] sel;

    always_comb begin
      sel = SEL_COMMA;
      case (state_q)
        DATA:    sel = valid[i] ? SEL_PASS : SEL_COMMA;
        SKIP:    sel = SEL_SKP;
        default: sel = SEL_COMMA;
      endcase
    end

    com_lane #(
      .W     (W),
      .COMMA (COMMA),
      .SKP   (SKP)
    ) u_lane (
      .clk   (cclk),
      .rst_n (default_values),
      .sel   (sel),
      .data  (data_in[i*W +: W]),
      .sym_o (data_out[i*W +: W]),
      .k_o   (k_out[i])
    );
  end

endmodule

// File: tb/tb_com_lane_inserter.sv
// Randomized bench for com_lane_inserter: three parameterisations against a cycle-position model.
module tb_com_lane_inserter;

  localparam int NL [3] = '{4, 8, 1};
  localparam int TL [3] = '{16, 4, 1};
  localparam int SI [3] = '{64, 2, 2};
  localparam int SL [3] = '{2, 1, 1};

  logic        cclk;
  logic        rst_n;
  logic        ftrain;
  logic [7:0]  vin [3];
  logic [63:0] din [3];
  logic [63:0] dout [3];
  logic [7:0]  kout [3];
  logic        rdy [3];
  logic        trn [3];

  logic [31:0] dout_a;
  logic [63:0] dout_b;
  logic [7:0]  dout_c;
  logic [3:0]  kout_a;
  logic [7:0]  kout_b;
  logic        kout_c;

  com_lane_inserter #(.LANES(4)) dut_a (
    .cclk(cclk), .default_values(rst_n), .force_train(ftrain),
    .valid(vin[0][3:0]), .data_in(din[0][31:0]),
    .ready(rdy[0]), .data_out(dout_a), .k_out(kout_a), .training(trn[0])
  );

  com_lane_inserter #(.LANES(8), .TRAIN_LEN(4), .SKP_INTERVAL(2), .SKP_LEN(1)) dut_b (
    .cclk(cclk), .default_values(rst_n), .force_train(ftrain),
    .valid(vin[1]), .data_in(din[1]),
    .ready(rdy[1]), .data_out(dout_b), .k_out(kout_b), .training(trn[1])
  );

  com_lane_inserter #(.LANES(1), .TRAIN_LEN(1), .SKP_INTERVAL(2), .SKP_LEN(1)) dut_c (
    .cclk(cclk), .default_values(rst_n), .force_train(ftrain),
    .valid(vin[2][0:0]), .data_in(din[2][7:0]),
    .ready(rdy[2]), .data_out(dout_c), .k_out(kout_c), .training(trn[2])
  );

  assign dout[0] = {32'd0, dout_a};
  assign dout[1] = dout_b;
  assign dout[2] = {56'd0, dout_c};
  assign kout[0] = {4'd0, kout_a};
  assign kout[1] = kout_b;
  assign kout[2] = {7'd0, kout_c};

  initial begin
    cclk = 1'b0;
    forever #5 cclk = ~cclk;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          t [3];
  logic [63:0] exp_out [3];
  logic [7:0]  exp_k [3];
  logic        accepted [3];
  int          mode;
  logic [7:0]  seq;
  logic [7:0]  prev_byte;
  logic        have_prev;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // 0 = training, 1 = data, 2 = skip, from the position since the last (re)train.
  function automatic int phase(input int k, input int tt);
    if (tt < TL[k]) return 0;
    return (((tt - TL[k]) % (SI[k] + SL[k])) < SI[k]) ? 1 : 2;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      exp_out[k] = '0;
      exp_k[k]   = '0;
      if (!rst_n) begin
        t[k]        = 0;
        accepted[k] = 1'b0;
      end else begin
        int ph;
        ph = phase(k, t[k]);
        for (int l = 0; l < NL[k]; l++) begin
          if (ph == 1 && vin[k][l]) begin
            exp_out[k][l*8 +: 8] = din[k][l*8 +: 8];
          end else begin
            exp_out[k][l*8 +: 8] = (ph == 2) ? 8'h1C : 8'hBC;
            exp_k[k][l]          = 1'b1;
          end
        end
        accepted[k] = (ph == 1);
        t[k]        = ftrain ? 0 : t[k] + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("dout%0d", k), dout[k], exp_out[k]);
      check_eq($sformatf("kout%0d", k), {56'd0, kout[k]}, {56'd0, exp_k[k]});
      check_eq($sformatf("ready%0d", k), {63'd0, rdy[k]}, {63'd0, rst_n && phase(k, t[k]) == 1});
      check_eq($sformatf("training%0d", k), {63'd0, trn[k]}, {63'd0, !rst_n || phase(k, t[k]) == 0});
    end
    if (mode == 2 && kout_a[0] === 1'b0) begin
      if (have_prev) check_eq("seq_step", {56'd0, dout_a[7:0] - prev_byte}, 64'd4);
      prev_byte = dout_a[7:0];
      have_prev = 1'b1;
    end
  endtask

  task automatic new_data(input int k);
    if (mode == 2 && k == 0) begin
      vin[0] = 8'h0F;
      din[0] = {32'd0, seq + 8'd3, seq + 8'd2, seq + 8'd1, seq};
      seq    = seq + 8'd4;
    end else begin
      vin[k] = 8'($urandom) & 8'((1 << NL[k]) - 1);
      din[k] = {$urandom, $urandom};
    end
  endtask

  task automatic cycle();
    @(negedge cclk);
    if (mode == 3) begin
      ftrain = ($urandom_range(0, 49) == 0);
      rst_n  = ($urandom_range(0, 199) != 0);
    end
    if (mode != 0) begin
      for (int k = 0; k < 3; k++) if (accepted[k]) new_data(k);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      tick();
    end
  endtask

  initial begin
    int n;
    int cnt;
    mode      = 0;
    rst_n     = 1'b0;
    ftrain    = 1'b0;
    seq       = 8'd0;
    prev_byte = 8'd0;
    have_prev = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vin[k]      = '0;
      din[k]      = '0;
      t[k]        = 0;
      accepted[k] = 1'b1;
    end

    run(3);
    check_eq("rst_dout", dout[0], 64'd0);
    check_eq("rst_kout", {56'd0, kout[0]}, 64'd0);
    rst_n = 1'b1;
    run(16);
    check_eq("ready_after_train", {63'd0, rdy[0]}, 64'd1);

    vin[0] = 8'h05;
    din[0] = 64'h44332211;
    run(1);
    check_eq("vec0101_dout", dout[0], 64'hBC33BC11);
    check_eq("vec0101_kout", {56'd0, kout[0]}, 64'h0A);

    mode = 2;
    for (int k = 0; k < 3; k++) accepted[k] = 1'b1;
    run(70);
    mode = 1;

    n = 0;
    while (rdy[0] !== 1'b0 && n < 300) begin
      run(1);
      n++;
    end
    check_eq("skp_wait", {63'd0, n < 300}, 64'd1);
    run(1);
    check_eq("skp_second", {63'd0, rdy[0]}, 64'd0);
    ftrain = 1'b1;
    run(1);
    ftrain = 1'b0;
    cnt = trn[0] ? 1 : 0;
    while (trn[0] === 1'b1 && cnt < 100) begin
      run(1);
      if (trn[0] === 1'b1) cnt++;
    end
    check_eq("retrain_len", 64'(cnt), 64'd16);
    run(140);

    mode = 3;
    run(1500);
    mode   = 1;
    rst_n  = 1'b1;
    ftrain = 1'b0;
    run(20);

    n = 0;
    while (rdy[0] !== 1'b1 && n < 300) begin
      run(1);
      n++;
    end
    check_eq("data_wait", {63'd0, n < 300}, 64'd1);
    run(5);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    check_eq("mid_rst_dout", dout[0], 64'd0);
    check_eq("mid_rst_kout", {56'd0, kout[0]}, 64'd0);
    run(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
